// File: rtl/md_buffer_pkg.sv
// Shared constants for the metadata buffer stage: queue indices, metadata widths and
// drop-counter width.
package md_buffer_pkg;

    localparam int unsigned Q_TSN_EVEN = 0;
    localparam int unsigned Q_TSN_ODD  = 1;
    localparam int unsigned Q_RC       = 2;
    localparam int unsigned Q_BE       = 3;
    localparam int unsigned NUM_Q      = 4;

    localparam int unsigned MD_W       = 9;
    localparam int unsigned MD_RC_W    = 16;
    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/md_buffer_if.sv
// Upstream write / downstream scheduler bundle for md_buffer. The drop counters exist only
// when MB_DROP_CNT_EN is defined.
interface md_buffer_if
    import md_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5
);

    logic [MD_W-1:0]       in_mb_md0;
    logic                  in_mb_md0_wr;
    logic [MD_W-1:0]       in_mb_md1;
    logic                  in_mb_md1_wr;
    logic [MD_RC_W-1:0]    in_mb_md2;
    logic                  in_mb_md2_wr;
    logic [MD_W-1:0]       in_mb_md3;
    logic                  in_mb_md3_wr;
    logic                  in_mb_md0_rd;
    logic                  in_mb_md1_rd;
    logic                  in_mb_md2_rd;
    logic                  in_mb_md3_rd;

    logic [MD_W-1:0]       out_mb_md0;
    logic [MD_W-1:0]       out_mb_md1;
    logic [MD_RC_W-1:0]    out_mb_md2;
    logic [MD_W-1:0]       out_mb_md3;
    logic                  out_mb_md0_empty;
    logic                  out_mb_md1_empty;
    logic                  out_mb_md2_empty;
    logic                  out_mb_md3_empty;
    logic [DEPTH_LOG2:0]   out_mb_md0_usedw;
    logic [DEPTH_LOG2:0]   out_mb_md1_usedw;
    logic [DEPTH_LOG2:0]   out_mb_md2_usedw;
    logic [DEPTH_LOG2:0]   out_mb_md3_usedw;
    logic                  out_mb_md0_drop;
    logic                  out_mb_md1_drop;
    logic                  out_mb_md2_drop;
    logic                  out_mb_md3_drop;
`ifdef MB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] out_mb_md0_drop_cnt;
    logic [DROP_CNT_W-1:0] out_mb_md1_drop_cnt;
    logic [DROP_CNT_W-1:0] out_mb_md2_drop_cnt;
    logic [DROP_CNT_W-1:0] out_mb_md3_drop_cnt;
`endif

    modport master (
        output in_mb_md0, in_mb_md0_wr, in_mb_md1, in_mb_md1_wr,
        output in_mb_md2, in_mb_md2_wr, in_mb_md3, in_mb_md3_wr,
        output in_mb_md0_rd, in_mb_md1_rd, in_mb_md2_rd, in_mb_md3_rd,
        input  out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3,
        input  out_mb_md0_empty, out_mb_md1_empty, out_mb_md2_empty, out_mb_md3_empty,
        input  out_mb_md0_usedw, out_mb_md1_usedw, out_mb_md2_usedw, out_mb_md3_usedw,
        input  out_mb_md0_drop, out_mb_md1_drop, out_mb_md2_drop, out_mb_md3_drop
`ifdef MB_DROP_CNT_EN
        ,
        input  out_mb_md0_drop_cnt, out_mb_md1_drop_cnt,
        input  out_mb_md2_drop_cnt, out_mb_md3_drop_cnt
`endif
    );

    modport slave (
        input  in_mb_md0, in_mb_md0_wr, in_mb_md1, in_mb_md1_wr,
        input  in_mb_md2, in_mb_md2_wr, in_mb_md3, in_mb_md3_wr,
        input  in_mb_md0_rd, in_mb_md1_rd, in_mb_md2_rd, in_mb_md3_rd,
        output out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3,
        output out_mb_md0_empty, out_mb_md1_empty, out_mb_md2_empty, out_mb_md3_empty,
        output out_mb_md0_usedw, out_mb_md1_usedw, out_mb_md2_usedw, out_mb_md3_usedw,
        output out_mb_md0_drop, out_mb_md1_drop, out_mb_md2_drop, out_mb_md3_drop
`ifdef MB_DROP_CNT_EN
        ,
        output out_mb_md0_drop_cnt, out_mb_md1_drop_cnt,
        output out_mb_md2_drop_cnt, out_mb_md3_drop_cnt
`endif
    );

endinterface

// File: rtl/md_buffer_fifo.sv
// Show-ahead synchronous FIFO for one metadata queue, with drop pulse on rejected writes.
// MB_DROP_CNT_EN adds a saturating 16-bit drop counter.
module md_buffer_fifo
    import md_buffer_pkg::*;
#(
    parameter string       PLATFORM   = "xilinx",
    parameter int unsigned DATA_W     = MD_W,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   usedw_o,
    output logic                  drop_o
`ifdef MB_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W   = DEPTH_LOG2;
    localparam int unsigned USEDW_W = DEPTH_LOG2 + 1;
    localparam logic [USEDW_W-1:0] USED_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [USEDW_W-1:0] usedw_q, usedw_d;
    logic               empty_q, empty_d;
    logic               drop_q, drop_d;
    logic               wr_ok, rd_ok;
    logic [DATA_W-1:0]  head;

    always_comb begin
        rd_ok    = rd_i && (usedw_q != '0);
        // A pop in the same cycle frees the slot, so a full queue still accepts the write.
        wr_ok    = wr_i && ((usedw_q != USED_MAX) || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        usedw_d  = usedw_q;
        case ({wr_ok, rd_ok})
            2'b10:   usedw_d = usedw_q + USEDW_W'(1);
            2'b01:   usedw_d = usedw_q - USEDW_W'(1);
            default: usedw_d = usedw_q;
        endcase
        empty_d  = (usedw_d == '0);
        drop_d   = wr_i && !wr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            drop_q   <= drop_d;
        end
    end

    if (PLATFORM == "xilinx") begin : g_lutram
        (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
        end
        assign head = mem[rd_ptr_q];
    end else begin : g_regs
        logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
        end
        assign head = mem[rd_ptr_q];
    end

    // Storage is not reset; masking with empty keeps the head at zero out of reset.
    assign rd_data_o = empty_q ? '0 : head;
    assign empty_o   = empty_q;
    assign usedw_o   = usedw_q;
    assign drop_o    = drop_q;

`ifdef MB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: rtl/md_buffer.sv
// Four parallel metadata queues (even TSN, odd TSN, reservation/PTP, best-effort) between
// the queue selector and the scheduler. MB_DROP_CNT_EN enables per-queue drop counters.
module md_buffer
    import md_buffer_pkg::*;
#(
    parameter string       PLATFORM   = "xilinx",
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    md_buffer_if.slave  mb
);

    md_buffer_fifo #(
        .PLATFORM   (PLATFORM),
        .DATA_W     (MD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_q_tsn_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (mb.in_mb_md0_wr),
        .wr_data_i  (mb.in_mb_md0),
        .rd_i       (mb.in_mb_md0_rd),
        .rd_data_o  (mb.out_mb_md0),
        .empty_o    (mb.out_mb_md0_empty),
        .usedw_o    (mb.out_mb_md0_usedw),
        .drop_o     (mb.out_mb_md0_drop)
`ifdef MB_DROP_CNT_EN
        ,
        .drop_cnt_o (mb.out_mb_md0_drop_cnt)
`endif
    );

    md_buffer_fifo #(
        .PLATFORM   (PLATFORM),
        .DATA_W     (MD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_q_tsn_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (mb.in_mb_md1_wr),
        .wr_data_i  (mb.in_mb_md1),
        .rd_i       (mb.in_mb_md1_rd),
        .rd_data_o  (mb.out_mb_md1),
        .empty_o    (mb.out_mb_md1_empty),
        .usedw_o    (mb.out_mb_md1_usedw),
        .drop_o     (mb.out_mb_md1_drop)
`ifdef MB_DROP_CNT_EN
        ,
        .drop_cnt_o (mb.out_mb_md1_drop_cnt)
`endif
    );

    md_buffer_fifo #(
        .PLATFORM   (PLATFORM),
        .DATA_W     (MD_RC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_q_rc (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (mb.in_mb_md2_wr),
        .wr_data_i  (mb.in_mb_md2),
        .rd_i       (mb.in_mb_md2_rd),
        .rd_data_o  (mb.out_mb_md2),
        .empty_o    (mb.out_mb_md2_empty),
        .usedw_o    (mb.out_mb_md2_usedw),
        .drop_o     (mb.out_mb_md2_drop)
`ifdef MB_DROP_CNT_EN
        ,
        .drop_cnt_o (mb.out_mb_md2_drop_cnt)
`endif
    );

    md_buffer_fifo #(
        .PLATFORM   (PLATFORM),
        .DATA_W     (MD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_q_be (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (mb.in_mb_md3_wr),
        .wr_data_i  (mb.in_mb_md3),
        .rd_i       (mb.in_mb_md3_rd),
        .rd_data_o  (mb.out_mb_md3),
        .empty_o    (mb.out_mb_md3_empty),
        .usedw_o    (mb.out_mb_md3_usedw),
        .drop_o     (mb.out_mb_md3_drop)
`ifdef MB_DROP_CNT_EN
        ,
        .drop_cnt_o (mb.out_mb_md3_drop_cnt)
`endif
    );

endmodule

// File: doc/md_buffer.md
# md_buffer

Metadata buffer stage directly downstream of the queue-selecting stage. It holds four independent metadata queues: even-slot TSN, odd-slot TSN, bandwidth-reservation/PTP, and best-effort. Each queue is a show-ahead synchronous FIFO, written by the upstream write strobes and drained by the downstream gate-control/scheduler stage. Writes to a full queue are dropped and reported.

## Interface
- PLATFORM, "xilinx": target family; selects register-array storage style only.
- DEPTH_LOG2, 5: log2 of entries per queue; each queue holds 2^DEPTH_LOG2 entries.
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_mb_md0 / in_mb_md0_wr  input  9 / 1  even-slot TSN metadata and write strobe.
- in_mb_md1 / in_mb_md1_wr  input  9 / 1  odd-slot TSN metadata and write strobe.
- in_mb_md2 / in_mb_md2_wr  input  16 / 1  reservation/PTP metadata ([15:9] token cost, [8:0] descriptor) and write strobe.
- in_mb_md3 / in_mb_md3_wr  input  9 / 1  best-effort metadata and write strobe.
- in_mb_mdN_rd  input  1 each (N=0..3)  pop request from the scheduler.
- out_mb_mdN  output  9/9/16/9  head entry of queue N (show-ahead).
- out_mb_mdN_empty  output  1 each  queue N holds no entry.
- out_mb_mdN_usedw  output  DEPTH_LOG2+1 each  entry count of queue N, range 0..2^DEPTH_LOG2.
- out_mb_mdN_drop  output  1 each  one-cycle pulse when a write to queue N was discarded.
- out_mb_mdN_drop_cnt  output  16 each  present only with MB_DROP_CNT_EN.

## Operation
- All four queues are identical apart from data width and operate fully in parallel, with no cross-queue interaction.
- Accepted write: wr=1 and (usedw<2^DEPTH_LOG2, or rd accepted in the same cycle). Entry is stored at the write pointer; the write pointer increments.
- Accepted read: rd=1 and usedw>0. The read pointer increments.
- Pointers are DEPTH_LOG2 bits and wrap naturally from 2^DEPTH_LOG2−1 to 0. usedw is a separate counter: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Full with simultaneous rd and wr: both are accepted, usedw stays at maximum, and no drop occurs.
- Empty with simultaneous rd and wr: the read is ignored, the write is stored, and usedw becomes 1.
- Rejected write (full, no read): data discarded, drop pulses for 1 cycle, stored contents unchanged.
- Rejected read (empty): no effect, no error indication.
- out_mb_mdN always shows the entry at the read pointer. When empty its value is don't-care; the scheduler must not sample it.
- Reset mid-operation empties all queues immediately. Entries are lost; no flush handshake.
- Reset values: pointers 0, usedw 0, empty 1, drop 0, drop_cnt 0, out_mb_mdN 0. Storage array contents are not reset.

## Timing
- Write-to-visible latency: 1 cycle. A write at cycle T gives empty=0, usedw updated and head valid from T+1.
- Read: pop at cycle T; the next entry appears on out_mb_mdN at T+1.
- Back-to-back reads every cycle are supported while usedw>0.
- Back-to-back writes every cycle are supported (matches the upstream one-strobe-per-cycle behaviour).
- Drop pulse asserts at T+1 for a rejected write at T.
- empty, usedw and drop are registered. out_mb_mdN is a register-array read at the registered read pointer, with no combinational path from inputs.

## Configuration
- MB_DROP_CNT_EN defined:
  - Each queue has a 16-bit drop counter.
  - It increments on every rejected write and saturates at 0xFFFF.
  - It is cleared only by reset.
- MB_DROP_CNT_EN undefined: out_mb_mdN_drop_cnt ports and counters are absent. The drop pulse remains.

## Structure
- Shared package holds:
  - queue index constants (Q_TSN_EVEN=0, Q_TSN_ODD=1, Q_RC=2, Q_BE=3);
  - metadata widths (MD_W=9, MD_RC_W=16);
  - DROP_CNT_W=16.
- Sub-module md_buffer_fifo (parameters DATA_W, DEPTH_LOG2) contains storage, pointers, usedw, drop logic and the optional counter. The top level instantiates it four times.

## Test plan
- Reset, then write 0x0A5 to queue 0 at T: at T+1 empty=0, usedw=1, out_mb_md0=0x0A5. Pop at T+1: empty=1 at T+2.
- Fill queue 1 with 32 writes (0x000..0x01F), then one more write of 0x1FF: drop pulses once, usedw=32, drain order is 0x000..0x01F, and drop_cnt=1 if enabled.
- Queue 2 full, simultaneous rd and wr of 0xFFFF: no drop, usedw stays 32, and 0xFFFF emerges last.
- Queue 3 empty, simultaneous rd and wr of 0x123: usedw=1, head=0x123.
- Write 40 entries into queue 0 with interleaved pops to force pointer wrap: FIFO order is preserved and usedw matches a reference model.
- Assert rst_n low mid-traffic with all queues half full: all empty=1 and usedw=0 immediately. Writes after release are accepted normally.
